// File: rtl/grf_sb.sv
// General register file with per-register issue scoreboard; register 0 reads as zero.
// Optional write-through forwarding from the write port to the read ports: define GRF_BYPASS_EN.
module grf_sb #(
    parameter int DW  = 32,
    parameter int AW  = 5,
    parameter int NRD = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [AW-1:0]     wa,
    input  logic [DW-1:0]     wd,
    input  logic              iss_v,
    input  logic [AW-1:0]     iss_a,
    input  logic [NRD*AW-1:0] ra,
    output logic [NRD*DW-1:0] rd,
    output logic [NRD-1:0]    rbusy,
    output logic              any_busy
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0]    r_regs [DEPTH];
    logic [DEPTH-1:0] r_busy;

    logic w_wr_en;
    logic w_iss_en;

    assign w_wr_en  = we && (wa != '0);
    assign w_iss_en = iss_v && (iss_a != '0);

    // Issue is applied after writeback so a same-cycle issue to the same register leaves it busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
            r_busy <= '0;
        end else begin
            if (w_wr_en) begin
                r_regs[wa] <= wd;
                r_busy[wa] <= 1'b0;
            end
            if (w_iss_en) begin
                r_busy[iss_a] <= 1'b1;
            end
        end
    end

    assign any_busy = |r_busy;

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] w_ra;
        logic [DW-1:0] w_rd;
        logic          w_rbusy;

        assign w_ra = ra[k*AW +: AW];

        always_comb begin
            w_rd    = '0;
            w_rbusy = 1'b0;
            if (w_ra != '0) begin
                w_rd    = r_regs[w_ra];
                w_rbusy = r_busy[w_ra];
            end
`ifdef GRF_BYPASS_EN
            // A same-cycle issue to the written register marks the forwarded value as stale again.
            if (!rst && w_wr_en && (w_ra == wa)) begin
                w_rd    = wd;
                w_rbusy = w_iss_en && (iss_a == wa);
            end
`endif
        end

        assign rd[k*DW +: DW] = w_rd;
        assign rbusy[k]       = w_rbusy;
    end

endmodule

// File: tb/tb_grf_sb.sv
// Directed bench for grf_sb (DW=32, AW=5, NRD=2) with a queue of expected read-port results.
module tb_grf_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        iss_v;
    logic [4:0]  iss_a;
    logic [9:0]  ra;
    logic [63:0] rd;
    logic [1:0]  rbusy;
    logic        any_busy;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       tag;
        logic [31:0] rd0;
        logic [31:0] rd1;
        logic [1:0]  rb;
        logic        ab;
    } exp_t;

    exp_t sb_q[$];

    grf_sb #(.DW(32), .AW(5), .NRD(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .we       (we),
        .wa       (wa),
        .wd       (wd),
        .iss_v    (iss_v),
        .iss_a    (iss_a),
        .ra       (ra),
        .rd       (rd),
        .rbusy    (rbusy),
        .any_busy (any_busy)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [31:0] rd0, input logic [31:0] rd1,
                        input logic [1:0] rb, input logic ab);
        exp_t e;
        e.tag = tag; e.rd0 = rd0; e.rd1 = rd1; e.rb = rb; e.ab = ab;
        sb_q.push_back(e);
    endtask

    // Sample at the falling edge, then advance past the next rising edge.
    task automatic step();
        exp_t e;
        @(negedge clk);
        while (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            cmp({e.tag, ".rd0"},   rd[31:0],           e.rd0);
            cmp({e.tag, ".rd1"},   rd[63:32],          e.rd1);
            cmp({e.tag, ".rbusy"}, {30'd0, rbusy},     {30'd0, e.rb});
            cmp({e.tag, ".any"},   {31'd0, any_busy},  {31'd0, e.ab});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; we = 1'b0; wa = '0; wd = '0; iss_v = 1'b0; iss_a = '0; ra = '0;
    endtask

    task automatic set_ra(input logic [4:0] a0, input logic [4:0] a1);
        ra = {a1, a0};
    endtask

    initial begin
        idle();
        rst = 1'b1;
        we = 1'b1; wa = 5'd7; wd = 32'hFFFF_FFFF; iss_v = 1'b1; iss_a = 5'd7;
        step();

        // Reset state swept over every address on both ports
        idle();
        for (int i = 0; i < 32; i++) begin
            set_ra(i[4:0], 5'(31 - i));
            push("reset_sweep", 32'd0, 32'd0, 2'b00, 1'b0);
            step();
        end

        // Full-width write, then read on both ports
        idle(); we = 1'b1; wa = 5'd5; wd = 32'hDEAD_BEEF;
        step();
        idle(); set_ra(5'd5, 5'd5);
        push("wr5_read", 32'hDEAD_BEEF, 32'hDEAD_BEEF, 2'b00, 1'b0);
        step();

        // Write to register 0 is dropped
        idle(); we = 1'b1; wa = 5'd0; wd = 32'h0000_1234;
        step();
        idle(); set_ra(5'd0, 5'd5);
        push("wr0_ignored", 32'd0, 32'hDEAD_BEEF, 2'b00, 1'b0);
        step();

        // Issue marks busy; writeback clears it
        idle(); iss_v = 1'b1; iss_a = 5'd8;
        step();
        idle(); set_ra(5'd0, 5'd8);
        push("iss8_busy", 32'd0, 32'd0, 2'b10, 1'b1);
        step();
        idle(); we = 1'b1; wa = 5'd8; wd = 32'd7;
        step();
        idle(); set_ra(5'd0, 5'd8);
        push("wb8_clear", 32'd0, 32'd7, 2'b00, 1'b0);
        step();

        // Simultaneous issue and write on the same register: data updates, busy stays
        idle(); we = 1'b1; wa = 5'd9; wd = 32'd3; iss_v = 1'b1; iss_a = 5'd9;
        step();
        idle(); set_ra(5'd9, 5'd0);
        push("iss_wr9_same", 32'd3, 32'd0, 2'b01, 1'b1);
        step();

        // Issue to register 0 has no effect
        idle(); iss_v = 1'b1; iss_a = 5'd0;
        step();
        idle(); set_ra(5'd0, 5'd9);
        push("iss0_ignored", 32'd0, 32'd3, 2'b10, 1'b1);
        step();

        // Re-issue to a busy register, then a single writeback clears it
        idle(); iss_v = 1'b1; iss_a = 5'd9;
        step();
        idle(); we = 1'b1; wa = 5'd9; wd = 32'd4;
        step();
        idle(); set_ra(5'd9, 5'd0);
        push("reissue9_clear", 32'd4, 32'd0, 2'b00, 1'b0);
        step();

        // Issue and write to different registers in one cycle
        idle(); iss_v = 1'b1; iss_a = 5'd10; we = 1'b1; wa = 5'd11; wd = 32'd55;
        step();
        idle(); set_ra(5'd10, 5'd11);
        push("iss10_wr11", 32'd0, 32'd55, 2'b01, 1'b1);
        step();
        idle(); we = 1'b1; wa = 5'd10; wd = 32'd66;
        step();
        idle(); set_ra(5'd10, 5'd11);
        push("wb10_clear", 32'd66, 32'd55, 2'b00, 1'b0);
        step();

        // Same-cycle write and read of register 4
        idle(); we = 1'b1; wa = 5'd4; wd = 32'hA5A5_A5A5; set_ra(5'd4, 5'd5);
`ifdef GRF_BYPASS_EN
        push("bypass_wr4", 32'hA5A5_A5A5, 32'hDEAD_BEEF, 2'b00, 1'b0);
`else
        push("bypass_wr4", 32'd0, 32'hDEAD_BEEF, 2'b00, 1'b0);
`endif
        step();
        idle(); set_ra(5'd4, 5'd0);
        push("after_wr4", 32'hA5A5_A5A5, 32'd0, 2'b00, 1'b0);
        step();

        // Same-cycle write, issue and read of register 4
        idle(); we = 1'b1; wa = 5'd4; wd = 32'd1; iss_v = 1'b1; iss_a = 5'd4; set_ra(5'd4, 5'd0);
`ifdef GRF_BYPASS_EN
        push("bypass_wr_iss4", 32'd1, 32'd0, 2'b01, 1'b0);
`else
        push("bypass_wr_iss4", 32'hA5A5_A5A5, 32'd0, 2'b00, 1'b0);
`endif
        step();
        idle(); set_ra(5'd4, 5'd0);
        push("after_wr_iss4", 32'd1, 32'd0, 2'b01, 1'b1);
        step();
        idle(); we = 1'b1; wa = 5'd4; wd = 32'd2;
        step();

        // Reset priority over a concurrent write and issue; pending busy bits are lost
        idle(); we = 1'b1; wa = 5'd3; wd = 32'd77; iss_v = 1'b1; iss_a = 5'd12;
        step();
        idle(); rst = 1'b1; we = 1'b1; wa = 5'd3; wd = 32'd1; iss_v = 1'b1; iss_a = 5'd3;
        set_ra(5'd3, 5'd12);
        push("rst_cycle_no_fwd", 32'd77, 32'd0, 2'b10, 1'b1);
        step();
        idle(); set_ra(5'd3, 5'd5);
        push("rst_priority", 32'd0, 32'd0, 2'b00, 1'b0);
        step();

        // Writeback after reset to a register whose busy bit was already cleared
        idle(); we = 1'b1; wa = 5'd12; wd = 32'd9;
        step();
        idle(); set_ra(5'd3, 5'd12);
        push("wb_after_rst", 32'd0, 32'd9, 2'b00, 1'b0);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/grf_sb.md
Name: grf_sb

Overview:
- Parametrised general register file for the pipelined MIPS core: one write port, NRD combinational read ports, register 0 hardwired to zero.
- Adds a per-register scoreboard. A busy bit is set when an instruction that writes a register issues, and cleared when that register is written back.
- Read ports report each register's value and its busy flag, so hazard control can stall without its own tracking.
- Sits between decode (reads, issue) and writeback (write).

Parameters:
DW, 32, data width in bits
AW, 5, address width; depth = 2**AW registers
NRD, 2, number of read ports (>=1)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
we  input  1  write enable
wa  input  AW  write address
wd  input  DW  write data
iss_v  input  1  issue valid; marks iss_a busy
iss_a  input  AW  destination register of issuing instruction
ra  input  NRD*AW  read addresses; port k uses bits [k*AW +: AW]
rd  output  NRD*DW  read data; port k uses bits [k*DW +: DW]
rbusy  output  NRD  busy flag of register ra[k]
any_busy  output  1  OR of all busy bits

Behaviour:
- Reset, rising edge with rst=1:
  - all 2**AW registers <= 0 and all busy bits <= 0.
  - rst has priority over we and iss_v in the same cycle; that write and that issue are dropped.
- Reset values of outputs follow from the cleared state: rd = 0, rbusy = 0, any_busy = 0.
- Write, when rst=0, we=1 and wa!=0: reg[wa] <= wd and busy[wa] <= 0 on the edge.
- Writes with wa=0 are ignored.
- Issue, when rst=0, iss_v=1 and iss_a!=0: busy[iss_a] <= 1.
- Issues with iss_a=0 are ignored; busy[0] is always 0.
- Issue and write to the same non-zero address in one cycle:
  - busy ends at 1, because the new producer wins;
  - the register data is still updated with wd.
- Issue and write to different addresses in one cycle: both take effect independently.
- Issuing to an already-busy register: busy stays 1, with no counting. Only one outstanding producer per register is tracked, and the decode stage enforces this.
- Reads are combinational with zero latency:
  - rd[k] = reg[ra[k]], and ra[k]=0 always gives rd[k] = 0;
  - rbusy[k] = busy[ra[k]];
  - any_busy = |busy.
- Bypass behaviour is governed only by the optional feature below.
- Reset mid-operation: all pending busy bits are lost, and a writeback arriving after reset writes data normally; clearing an already-clear busy bit is harmless.
- Port widths scale with parameters. No width truncation anywhere: wd is stored at the full DW width.

Optional Feature:
- Macro: GRF_BYPASS_EN.
- Defined: write-through forwarding. When rst=0, we=1, wa!=0 and ra[k]==wa in the same cycle:
  - rd[k] = wd;
  - rbusy[k] = 0, unless iss_v=1 and iss_a==wa in the same cycle, in which case rbusy[k] = 1.
  - No forwarding occurs while rst=1.
- Undefined: rd and rbusy always reflect registered state only. A same-cycle write becomes visible the cycle after the edge.

Test Plan:
- Reset: after rst=1 for 1 cycle, all ra sweep 0..31 -> rd=0, rbusy=0, any_busy=0.
- Write/read: we=1, wa=5, wd=32'hDEADBEEF, then ra0=5 the next cycle -> rd0=DEADBEEF. Write to wa=0 with wd=32'h1234 -> ra0=0 reads 0.
- Scoreboard: iss_v=1, iss_a=8 -> next cycle ra1=8 gives rbusy1=1 and any_busy=1. Then we=1, wa=8, wd=7 -> next cycle rbusy1=0, rd1=7, any_busy=0.
- Simultaneous issue and write on reg 9 with wd=3 -> next cycle busy[9]=1 and rd=3. Issue to 0 -> rbusy=0.
- Bypass: we=1, wa=4, wd=32'hA5A5A5A5, ra0=4 in the same cycle.
  - With GRF_BYPASS_EN: rd0=A5A5A5A5 that cycle.
  - Without: rd0 shows the old value that cycle and A5A5A5A5 the next.
- Reset priority: rst=1 together with we=1, wa=3, wd=1 and iss_v=1, iss_a=3 -> next cycle reg3=0, busy3=0.
